reg_file_responder: RTL and testbench

//  Register file at the receiving end of the write-back stage token protocol and the serving end of
//  the decode read request. Accepts the stage-5 write-back token (write enable, address, data), updates
//  the architectural registers, then returns the token as the stage-1 restart pulse. Also serves
//  two-operand reads for the decode->ALU hand-off, with write-before-read bypass.

---
 rtl/reg_file_responder_if.sv | 38 +++
 rtl/reg_file_responder.sv | 97 +++++++++
 tb/tb_reg_file_responder.sv | 334 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/reg_file_responder_if.sv
// Register-file bus: write-back token, decode read request and status outputs.
// Latency: n/a (signal bundle only).
// Backpressure: none; tokens are single-cycle pulses with no ready signal.
interface reg_file_responder_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 16
);
  logic              rd_stage_in;
  logic [ADDR_W-1:0] rs_addr;
  logic [ADDR_W-1:0] rt_addr;
  logic [DATA_W-1:0] read_data1;
  logic [DATA_W-1:0] read_data2;
  logic              rd_stage_out;
  logic              wb_stage_in;
  logic              wb_en;
  logic [ADDR_W-1:0] wb_addr;
  logic [DATA_W-1:0] wb_data;
  logic              wb_stage_out;
  logic [CNT_W-1:0]  wr_count;
  logic              overlap_err;

  // Pipeline side: issues tokens, consumes read data and status
  modport master (
    output rd_stage_in, rs_addr, rt_addr,
    output wb_stage_in, wb_en, wb_addr, wb_data,
    input  read_data1, read_data2, rd_stage_out,
    input  wb_stage_out, wr_count, overlap_err
  );

  // Register-file side: consumes tokens, produces read data and status
  modport slave (
    input  rd_stage_in, rs_addr, rt_addr,
    input  wb_stage_in, wb_en, wb_addr, wb_data,
    output read_data1, read_data2, rd_stage_out,
    output wb_stage_out, wr_count, overlap_err
  );
endinterface

// File: rtl/reg_file_responder.sv
// Register file closing the write-back token ring and serving decode operand reads (write-first bypass).
// Latency: 1 cycle from input token to output token / registered read data.
// Backpressure: none; a token is accepted every cycle and each yields its own output pulse.
module reg_file_responder #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 16
) (
  input logic                 clock,
  input logic                 reset_n,
  reg_file_responder_if.slave bus
);

  localparam int NUM_REGS = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic [DATA_W-1:0] read_data1_q, read_data1_d;
  logic [DATA_W-1:0] read_data2_q, read_data2_d;
  logic              rd_stage_out_q, rd_stage_out_d;
  logic              wb_stage_out_q, wb_stage_out_d;
  logic [CNT_W-1:0]  wr_count_q, wr_count_d;
  logic              overlap_err_q, overlap_err_d;
  logic              wr_commit;

  // A write only lands when the token is present, enabled and not aimed at the zero register
  assign wr_commit = bus.wb_stage_in & bus.wb_en & (bus.wb_addr != '0);

  // Next-state: operand fetch with write-first bypass, token return, saturating count, sticky overlap
  always_comb begin
    read_data1_d   = read_data1_q;
    read_data2_d   = read_data2_q;
    rd_stage_out_d = bus.rd_stage_in;
    wb_stage_out_d = bus.wb_stage_in;
    wr_count_d     = wr_count_q;
    overlap_err_d  = overlap_err_q | (bus.rd_stage_in & bus.wb_stage_in);

    if (bus.rd_stage_in) begin
      if (bus.rs_addr == '0) begin
        read_data1_d = '0;
      end else if (wr_commit && (bus.wb_addr == bus.rs_addr)) begin
        read_data1_d = bus.wb_data;
      end else begin
        read_data1_d = regs_q[bus.rs_addr];
      end

      if (bus.rt_addr == '0) begin
        read_data2_d = '0;
      end else if (wr_commit && (bus.wb_addr == bus.rt_addr)) begin
        read_data2_d = bus.wb_data;
      end else begin
        read_data2_d = regs_q[bus.rt_addr];
      end
    end

    if (wr_commit && (wr_count_q != '1)) begin
      wr_count_d = wr_count_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  // Architectural registers; entry 0 is never written so it stays zero after reset
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else if (wr_commit) begin
      regs_q[bus.wb_addr] <= bus.wb_data;
    end
  end

  // Output registers; reset also drops any token that would have fired next cycle
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      read_data1_q   <= '0;
      read_data2_q   <= '0;
      rd_stage_out_q <= 1'b0;
      wb_stage_out_q <= 1'b0;
      wr_count_q     <= '0;
      overlap_err_q  <= 1'b0;
    end else begin
      read_data1_q   <= read_data1_d;
      read_data2_q   <= read_data2_d;
      rd_stage_out_q <= rd_stage_out_d;
      wb_stage_out_q <= wb_stage_out_d;
      wr_count_q     <= wr_count_d;
      overlap_err_q  <= overlap_err_d;
    end
  end

  assign bus.read_data1   = read_data1_q;
  assign bus.read_data2   = read_data2_q;
  assign bus.rd_stage_out = rd_stage_out_q;
  assign bus.wb_stage_out = wb_stage_out_q;
  assign bus.wr_count     = wr_count_q;
  assign bus.overlap_err  = overlap_err_q;

endmodule

// File: tb/tb_reg_file_responder.sv
// Bench for reg_file_responder: directed scenarios plus randomized traffic against a behavioural model.
// Latency: outputs are checked 1 time unit after the edge that produced them.
// Backpressure: n/a.
module tb_reg_file_responder;

  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 5;
  localparam int CNT_W    = 16;
  localparam int NUM_REGS = 32;
  localparam int CNT_MAX  = 65535;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;

  reg_file_responder_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) bus ();

  reg_file_responder #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .clock  (clock),
    .reset_n(reset_n),
    .bus    (bus)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_err = 0;

  // Behavioural model state: what the outputs should show after the most recent edge
  logic [31:0] m_regs [NUM_REGS];
  logic [31:0] m_rd1, m_rd2;
  logic        m_rdo, m_wbo, m_ovl;
  int unsigned m_cnt;

  function automatic logic [31:0] mdl_read(input logic [4:0] a, input logic wq);
    if (a == 5'd0) return 32'h0;
    if (wq && (a == bus.wb_addr)) return bus.wb_data;
    return m_regs[a];
  endfunction

  // Advance the model with the inputs presented now, then clock the DUT
  task automatic tick();
    logic wq;
    if (!reset_n) begin
      foreach (m_regs[i]) m_regs[i] = 32'h0;
      m_rd1 = 0; m_rd2 = 0; m_rdo = 0; m_wbo = 0; m_ovl = 0; m_cnt = 0;
    end else begin
      wq = bus.wb_stage_in && bus.wb_en && (bus.wb_addr != 5'd0);
      if (bus.rd_stage_in) begin
        m_rd1 = mdl_read(bus.rs_addr, wq);
        m_rd2 = mdl_read(bus.rt_addr, wq);
      end
      m_rdo = bus.rd_stage_in;
      m_wbo = bus.wb_stage_in;
      if (wq) begin
        m_regs[bus.wb_addr] = bus.wb_data;
        if (m_cnt < CNT_MAX) m_cnt++;
      end
      if (bus.rd_stage_in && bus.wb_stage_in) m_ovl = 1'b1;
    end
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    bus.rd_stage_in = 1'b0;
    bus.wb_stage_in = 1'b0;
    bus.wb_en       = 1'b0;
  endtask

  task automatic set_wb(input logic en, input logic [4:0] a, input logic [31:0] d);
    bus.wb_stage_in = 1'b1;
    bus.wb_en       = en;
    bus.wb_addr     = a;
    bus.wb_data     = d;
  endtask

  task automatic set_rd(input logic [4:0] rs, input logic [4:0] rt);
    bus.rd_stage_in = 1'b1;
    bus.rs_addr     = rs;
    bus.rt_addr     = rt;
  endtask

  task automatic test_reset();
    logic [82:0] got;
    idle();
    bus.rs_addr = 0; bus.rt_addr = 0; bus.wb_addr = 0; bus.wb_data = 0;
    reset_n = 1'b0;
    tick();
    tick();
    got = {bus.read_data1, bus.read_data2, bus.rd_stage_out, bus.wb_stage_out, bus.wr_count, bus.overlap_err};
    n_cmp++;
    if (got !== 83'h0) begin
      n_err++;
      $display("FAIL reset_outputs: got %h want 0", got);
    end
    reset_n = 1'b1;
    for (int i = 0; i < NUM_REGS; i++) begin
      set_rd(5'(i), 5'(NUM_REGS - 1 - i));
      tick();
      n_cmp++;
      if ({bus.read_data1, bus.read_data2, bus.rd_stage_out, bus.wb_stage_out, bus.wr_count}
          !== {64'h0, 1'b1, 1'b0, 16'h0}) begin
        n_err++;
        $display("FAIL reset_read r%0d: rd1=%h rd2=%h rdo=%b wbo=%b cnt=%h want 0/0/1/0/0",
                 i, bus.read_data1, bus.read_data2, bus.rd_stage_out, bus.wb_stage_out, bus.wr_count);
      end
    end
    idle();
    tick();
  endtask

  task automatic test_write_read();
    set_wb(1'b1, 5'd5, 32'hDEADBEEF);
    tick();
    n_cmp++;
    if ({bus.wb_stage_out, bus.rd_stage_out, bus.wr_count} !== {1'b1, 1'b0, 16'd1}) begin
      n_err++;
      $display("FAIL wr_token: wbo=%b rdo=%b cnt=%h want 1/0/0001", bus.wb_stage_out, bus.rd_stage_out, bus.wr_count);
    end
    idle();
    set_rd(5'd5, 5'd0);
    tick();
    n_cmp++;
    if ({bus.read_data1, bus.read_data2, bus.rd_stage_out, bus.wb_stage_out} !== {32'hDEADBEEF, 32'h0, 1'b1, 1'b0}) begin
      n_err++;
      $display("FAIL rd_after_wr: rd1=%h rd2=%h rdo=%b wbo=%b want deadbeef/0/1/0",
               bus.read_data1, bus.read_data2, bus.rd_stage_out, bus.wb_stage_out);
    end
    idle();
    tick();
    n_cmp++;
    if ({bus.read_data1, bus.rd_stage_out} !== {32'hDEADBEEF, 1'b0}) begin
      n_err++;
      $display("FAIL rd_hold: rd1=%h rdo=%b want deadbeef/0", bus.read_data1, bus.rd_stage_out);
    end
  endtask

  task automatic test_r0_write();
    set_wb(1'b1, 5'd0, 32'h1234);
    tick();
    n_cmp++;
    if ({bus.wb_stage_out, bus.wr_count} !== {1'b1, 16'd1}) begin
      n_err++;
      $display("FAIL r0_write: wbo=%b cnt=%h want 1/0001", bus.wb_stage_out, bus.wr_count);
    end
    idle();
    set_rd(5'd0, 5'd0);
    tick();
    n_cmp++;
    if ({bus.read_data1, bus.read_data2} !== 64'h0) begin
      n_err++;
      $display("FAIL r0_read: rd1=%h rd2=%h want 0/0", bus.read_data1, bus.read_data2);
    end
    idle();
    tick();
  endtask

  task automatic test_disabled_write();
    set_wb(1'b0, 5'd3, 32'h0000FFFF);
    tick();
    n_cmp++;
    if ({bus.wb_stage_out, bus.wr_count} !== {1'b1, 16'd1}) begin
      n_err++;
      $display("FAIL en0_write: wbo=%b cnt=%h want 1/0001", bus.wb_stage_out, bus.wr_count);
    end
    idle();
    set_rd(5'd3, 5'd5);
    tick();
    n_cmp++;
    if ({bus.read_data1, bus.read_data2} !== {32'h0, 32'hDEADBEEF}) begin
      n_err++;
      $display("FAIL en0_read: rd1=%h rd2=%h want 0/deadbeef", bus.read_data1, bus.read_data2);
    end
    idle();
    tick();
  endtask

  task automatic test_overlap();
    set_wb(1'b1, 5'd7, 32'hA5A5A5A5);
    set_rd(5'd7, 5'd7);
    tick();
    n_cmp++;
    if ({bus.read_data1, bus.read_data2, bus.rd_stage_out, bus.wb_stage_out, bus.overlap_err}
        !== {32'hA5A5A5A5, 32'hA5A5A5A5, 1'b1, 1'b1, 1'b1}) begin
      n_err++;
      $display("FAIL overlap_bypass: rd1=%h rd2=%h rdo=%b wbo=%b ovl=%b want a5a5a5a5/a5a5a5a5/1/1/1",
               bus.read_data1, bus.read_data2, bus.rd_stage_out, bus.wb_stage_out, bus.overlap_err);
    end
    idle();
    for (int k = 0; k < 3; k++) begin
      tick();
      n_cmp++;
      if ({bus.overlap_err, bus.rd_stage_out, bus.wb_stage_out} !== 3'b100) begin
        n_err++;
        $display("FAIL overlap_sticky c%0d: ovl=%b rdo=%b wbo=%b want 1/0/0",
                 k, bus.overlap_err, bus.rd_stage_out, bus.wb_stage_out);
      end
    end
    set_rd(5'd7, 5'd0);
    tick();
    n_cmp++;
    if (bus.read_data1 !== 32'hA5A5A5A5) begin
      n_err++;
      $display("FAIL overlap_commit: rd1=%h want a5a5a5a5", bus.read_data1);
    end
    idle();
    tick();
  endtask

  task automatic test_back_to_back();
    logic [31:0] d [4];
    for (int k = 0; k < 4; k++) begin
      d[k] = $urandom;
      set_wb(1'b1, 5'(10 + k), d[k]);
      set_rd(5'(k == 0 ? 5 : 10 + k - 1), 5'd0);
      tick();
      n_cmp++;
      if ({bus.wb_stage_out, bus.rd_stage_out, bus.read_data1}
          !== {1'b1, 1'b1, (k == 0) ? 32'hDEADBEEF : d[k-1]}) begin
        n_err++;
        $display("FAIL b2b c%0d: wbo=%b rdo=%b rd1=%h want 1/1/%h",
                 k, bus.wb_stage_out, bus.rd_stage_out, bus.read_data1, (k == 0) ? 32'hDEADBEEF : d[k-1]);
      end
    end
    idle();
    tick();
    n_cmp++;
    if ({bus.wb_stage_out, bus.rd_stage_out, bus.wr_count} !== {1'b0, 1'b0, 16'd6}) begin
      n_err++;
      $display("FAIL b2b_end: wbo=%b rdo=%b cnt=%h want 0/0/0006", bus.wb_stage_out, bus.rd_stage_out, bus.wr_count);
    end
  endtask

  task automatic test_random();
    logic [82:0] got, exp;
    int bad = 0;
    idle();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      bus.rd_stage_in = ($urandom_range(0, 2) != 0);
      bus.wb_stage_in = ($urandom_range(0, 2) != 0);
      bus.wb_en       = ($urandom_range(0, 3) != 0);
      bus.rs_addr     = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 3));
      bus.rt_addr     = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 3));
      bus.wb_addr     = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 3));
      bus.wb_data     = $urandom;
      if (c < 200) bus.wb_stage_in = bus.wb_stage_in && !bus.rd_stage_in;
      tick();
      got = {bus.read_data1, bus.read_data2, bus.rd_stage_out, bus.wb_stage_out, bus.wr_count, bus.overlap_err};
      exp = {m_rd1, m_rd2, m_rdo, m_wbo, 16'(m_cnt), m_ovl};
      n_cmp++;
      if (got !== exp) begin
        n_err++;
        bad++;
        if (bad <= 10) $display("FAIL random c%0d: got %h want %h", c, got, exp);
      end
    end
    idle();
    tick();
  endtask

  task automatic test_saturate_reset();
    idle();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    for (int c = 0; c < 16'hFFFE; c++) begin
      set_wb(1'b1, 5'($urandom_range(1, 31)), $urandom);
      tick();
    end
    n_cmp++;
    if ({bus.wr_count, bus.wb_stage_out} !== {16'hFFFE, 1'b1}) begin
      n_err++;
      $display("FAIL sat_fffe: cnt=%h wbo=%b want fffe/1", bus.wr_count, bus.wb_stage_out);
    end
    tick();
    tick();
    n_cmp++;
    if (bus.wr_count !== 16'hFFFF) begin
      n_err++;
      $display("FAIL sat_ffff: cnt=%h want ffff", bus.wr_count);
    end
    set_wb(1'b1, 5'd9, 32'h13579BDF);
    tick();
    n_cmp++;
    if (bus.wr_count !== 16'hFFFF) begin
      n_err++;
      $display("FAIL sat_hold: cnt=%h want ffff", bus.wr_count);
    end
    set_wb(1'b1, 5'd9, 32'h2468ACE0);
    set_rd(5'd9, 5'd9);
    reset_n = 1'b0;
    tick();
    n_cmp++;
    if ({bus.read_data1, bus.read_data2, bus.rd_stage_out, bus.wb_stage_out, bus.wr_count, bus.overlap_err} !== 83'h0) begin
      n_err++;
      $display("FAIL reset_pending: rd1=%h rd2=%h rdo=%b wbo=%b cnt=%h ovl=%b want all 0",
               bus.read_data1, bus.read_data2, bus.rd_stage_out, bus.wb_stage_out, bus.wr_count, bus.overlap_err);
    end
    reset_n = 1'b1;
    idle();
    tick();
    n_cmp++;
    if ({bus.rd_stage_out, bus.wb_stage_out} !== 2'b00) begin
      n_err++;
      $display("FAIL reset_no_pulse: rdo=%b wbo=%b want 0/0", bus.rd_stage_out, bus.wb_stage_out);
    end
    set_rd(5'd9, 5'd9);
    tick();
    n_cmp++;
    if ({bus.read_data1, bus.read_data2, bus.wr_count} !== {64'h0, 16'h0}) begin
      n_err++;
      $display("FAIL reset_regs: rd1=%h rd2=%h cnt=%h want 0/0/0", bus.read_data1, bus.read_data2, bus.wr_count);
    end
    idle();
    tick();
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_r0_write();
    test_disabled_write();
    test_overlap();
    test_back_to_back();
    test_random();
    test_saturate_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
